// File: rtl/lcd_i2c_target_if.sv
// rtl/lcd_i2c_target_if.sv - I2C pin and decoded-command bundle for the LCD I2C target
`timescale 1ns/1ps

interface lcd_i2c_target_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_o;
    logic       sda_t;
    logic       scl_o;
    logic       scl_t;
    logic       cmd_valid;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       busy;
    logic       overflow;

    modport slave (
        input  scl_i, sda_i, cmd_ready,
        output sda_o, sda_t, scl_o, scl_t, cmd_valid, cmd_rs, cmd_data, busy, overflow
    );

    modport master (
        output scl_i, sda_i, cmd_ready,
        input  sda_o, sda_t, scl_o, scl_t, cmd_valid, cmd_rs, cmd_data, busy, overflow
    );
endinterface

// File: rtl/lcd_i2c_target.sv
// rtl/lcd_i2c_target.sv - AiP31068-style I2C LCD target; LCD_I2C_TARGET_STRETCH_EN enables clock stretching
`timescale 1ns/1ps

module lcd_i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h3E,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    lcd_i2c_target_if.slave   bus
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        CTRL,
        CTRL_ACK,
        DATA,
        DATA_ACK,
        DATA_NACK,
        STALL,
        STALL_REL,
        IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_d;
    logic                   sda_d;
    logic                   rise_q;
    logic                   fall_q;
    logic                   start_q;
    logic                   stop_q;
    logic                   bit_q;

    state_t                 state_q;
    state_t                 state_d;
    logic [7:0]             shreg;
    logic [2:0]             bit_cnt;
    logic                   byte_full;
    logic                   byte_end;
    logic                   shift_en;
    logic                   ack_q;
    logic                   busy_q;
    logic                   co_q;
    logic                   rs_q;
    logic                   cmd_valid_q;
    logic                   cmd_rs_q;
    logic [7:0]             cmd_data_q;
    logic                   ovf_q;

    logic                   ack_on;
    logic                   ack_off;
    logic                   busy_set;
    logic                   busy_clr;
    logic                   load;
    logic                   ovf_set;
    logic                   ctrl_latch;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Edge pulses are registered so every FSM action sees a clean one-cycle strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            bit_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
            rise_q   <= scl_s & ~scl_d;
            fall_q   <= ~scl_s & scl_d;
            start_q  <= scl_s & scl_d & sda_d & ~sda_s;
            stop_q   <= scl_s & scl_d & ~sda_d & sda_s;
            bit_q    <= sda_s;
        end
    end

    assign shift_en = (state_q == ADDR) || (state_q == CTRL) || (state_q == DATA);
    assign byte_end = fall_q && byte_full;

`ifdef LCD_I2C_TARGET_STRETCH_EN
    logic hold_q;
    logic hold_on;
    logic hold_off;
`endif

    always_comb begin
        state_d    = state_q;
        ack_on     = 1'b0;
        ack_off    = 1'b0;
        busy_set   = 1'b0;
        busy_clr   = 1'b0;
        load       = 1'b0;
        ovf_set    = 1'b0;
        ctrl_latch = 1'b0;
`ifdef LCD_I2C_TARGET_STRETCH_EN
        hold_on    = 1'b0;
        hold_off   = 1'b0;
`endif
        if (start_q || stop_q) begin
            state_d  = start_q ? ADDR : IDLE;
            ack_off  = 1'b1;
            busy_clr = 1'b1;
`ifdef LCD_I2C_TARGET_STRETCH_EN
            hold_off = 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (byte_end) begin
                        if (shreg[7:1] == DEV_ADDR && !shreg[0]) begin
                            state_d  = ADDR_ACK;
                            ack_on   = 1'b1;
                            busy_set = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (fall_q) begin
                        ack_off = 1'b1;
                        state_d = CTRL;
                    end
                end
                CTRL: begin
                    if (byte_end) begin
                        ctrl_latch = 1'b1;
                        ack_on     = 1'b1;
                        state_d    = CTRL_ACK;
                    end
                end
                CTRL_ACK: begin
                    if (fall_q) begin
                        ack_off = 1'b1;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (byte_end) begin
                        if (!cmd_valid_q || bus.cmd_ready) begin
                            load    = 1'b1;
                            ack_on  = 1'b1;
                            state_d = DATA_ACK;
                        end else begin
`ifdef LCD_I2C_TARGET_STRETCH_EN
                            hold_on = 1'b1;
                            state_d = STALL;
`else
                            ovf_set = 1'b1;
                            state_d = DATA_NACK;
`endif
                        end
                    end
                end
                DATA_ACK: begin
                    if (fall_q) begin
                        ack_off = 1'b1;
                        state_d = co_q ? CTRL : DATA;
                    end
                end
                DATA_NACK: begin
                    if (fall_q) begin
                        state_d = IGNORE;
                    end
                end
`ifdef LCD_I2C_TARGET_STRETCH_EN
                // SCL is held low here; the byte is accepted only once the consumer frees the register.
                STALL: begin
                    if (bus.cmd_ready) begin
                        load    = 1'b1;
                        ack_on  = 1'b1;
                        state_d = STALL_REL;
                    end
                end
                STALL_REL: begin
                    hold_off = 1'b1;
                    state_d  = DATA_ACK;
                end
`endif
                IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shreg       <= 8'h00;
            bit_cnt     <= 3'd0;
            byte_full   <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            co_q        <= 1'b0;
            rs_q        <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_rs_q    <= 1'b0;
            cmd_data_q  <= 8'h00;
            ovf_q       <= 1'b0;
        end else begin
            state_q <= state_d;

            // Bits only accumulate in the three byte-receiving states; a START discards a partial byte.
            if (start_q || !shift_en) begin
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
            end else if (rise_q && !byte_full) begin
                shreg   <= {shreg[6:0], bit_q};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_full <= 1'b1;
                end
            end

            if (ack_off) begin
                ack_q <= 1'b0;
            end else if (ack_on) begin
                ack_q <= 1'b1;
            end

            if (busy_clr) begin
                busy_q <= 1'b0;
            end else if (busy_set) begin
                busy_q <= 1'b1;
            end

            if (ctrl_latch) begin
                co_q <= shreg[7];
                rs_q <= shreg[6];
            end

            if (load) begin
                cmd_valid_q <= 1'b1;
                cmd_data_q  <= shreg;
                cmd_rs_q    <= rs_q;
            end else if (cmd_valid_q && bus.cmd_ready) begin
                cmd_valid_q <= 1'b0;
            end

            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

`ifdef LCD_I2C_TARGET_STRETCH_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_q <= 1'b0;
        end else if (hold_off) begin
            hold_q <= 1'b0;
        end else if (hold_on) begin
            hold_q <= 1'b1;
        end
    end

    assign bus.scl_t = ~hold_q;
`else
    assign bus.scl_t = 1'b1;
`endif

    assign bus.sda_o     = 1'b0;
    assign bus.scl_o     = 1'b0;
    assign bus.sda_t     = ~ack_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_rs    = cmd_rs_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.busy      = busy_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_lcd_i2c_target.sv
// tb/tb_lcd_i2c_target.sv - self-checking bench for lcd_i2c_target driving an open-drain I2C bus
`timescale 1ns/1ps

module tb_lcd_i2c_target;
    localparam int HALF = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic tb_scl  = 1'b1;
    logic tb_sda  = 1'b1;
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    lcd_i2c_target_if bus();

    assign bus.scl_i = tb_scl & (bus.scl_t | bus.scl_o);
    assign bus.sda_i = tb_sda & (bus.sda_t | bus.sda_o);

    lcd_i2c_target #(.DEV_ADDR(7'h3E), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level model of the LCD protocol
    logic [8:0] exp_q[$];
    bit         m_first, m_addr_ok, m_expect_ctrl, m_co, m_rs, m_ready_low, m_full;
    int         out_cnt     = 0;
    logic [8:0] last_out    = 9'h000;
    int         fall8_cyc   = -100;
    bit         prev_valid  = 1'b0;
    int         sda_low_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit model_byte(input logic [7:0] b);
        if (m_first) begin
            m_first   = 1'b0;
            m_addr_ok = (b == 8'h7C);
            return m_addr_ok;
        end
        if (!m_addr_ok) return 1'b0;
        if (m_expect_ctrl) begin
            m_co          = b[7];
            m_rs          = b[6];
            m_expect_ctrl = 1'b0;
            return 1'b1;
        end
        if (m_ready_low && m_full) begin
`ifdef LCD_I2C_TARGET_STRETCH_EN
            exp_q.push_back({m_rs, b});
            m_expect_ctrl = m_co;
            return 1'b1;
`else
            m_addr_ok = 1'b0;
            return 1'b0;
`endif
        end
        exp_q.push_back({m_rs, b});
        if (m_ready_low) m_full = 1'b1;
        m_expect_ctrl = m_co;
        return 1'b1;
    endfunction

    function automatic void model_start();
        m_first       = 1'b1;
        m_addr_ok     = 1'b0;
        m_expect_ctrl = 1'b1;
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got rs=%0d data=0x%02h, expected none",
                             bus.cmd_rs, bus.cmd_data);
                end else begin
                    check("output_byte", 32'({bus.cmd_rs, bus.cmd_data}), 32'(exp_q.pop_front()));
                end
                out_cnt++;
                last_out = {bus.cmd_rs, bus.cmd_data};
            end
            if (bus.cmd_valid && !prev_valid) check("valid_latency", cyc - fall8_cyc, 4);
            if (!bus.sda_t) sda_low_cnt++;
            prev_valid = bus.cmd_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scl_up();
        tb_scl = 1'b1;
        for (int i = 0; i < 3000 && bus.scl_i !== 1'b1; i++) clks(1);
        if (bus.scl_i !== 1'b1) check("scl_release_timeout", 32'(bus.scl_i), 1);
    endtask

    task automatic send_bit(input logic b);
        tb_sda = b;
        clks(4);
        scl_up();
        clks(HALF);
        fall8_cyc = cyc;
        tb_scl = 1'b0;
        clks(HALF);
    endtask

    task automatic ack_clock(output bit ack);
        tb_sda = 1'b1;
        clks(4);
        scl_up();
        clks(HALF / 2);
        ack = (bus.sda_i === 1'b0);
        clks(HALF / 2);
        tb_scl = 1'b0;
        clks(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input string name);
        bit exp_ack;
        bit ack;
        exp_ack = model_byte(b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_clock(ack);
        check(name, 32'(ack), 32'(exp_ack));
    endtask

    task automatic i2c_start();
        tb_sda = 1'b1;
        clks(4);
        if (tb_scl == 1'b0) scl_up();
        clks(HALF);
        tb_sda = 1'b0;
        clks(HALF);
        tb_scl = 1'b0;
        clks(HALF);
        model_start();
    endtask

    task automatic i2c_stop();
        tb_sda = 1'b0;
        clks(4);
        scl_up();
        clks(HALF);
        tb_sda = 1'b1;
        clks(2 * HALF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int cnt0;
        int low0;
        bus.cmd_ready = 1'b1;
        m_ready_low   = 1'b0;
        m_full        = 1'b0;
        model_start();
        reset_n = 1'b0;
        clks(4);
        check("rst_sda_t",     32'(bus.sda_t), 1);
        check("rst_scl_t",     32'(bus.scl_t), 1);
        check("rst_cmd_valid", 32'(bus.cmd_valid), 0);
        check("rst_cmd_rs",    32'(bus.cmd_rs), 0);
        check("rst_cmd_data",  32'(bus.cmd_data), 0);
        check("rst_busy",      32'(bus.busy), 0);
        check("rst_overflow",  32'(bus.overflow), 0);
        check("rst_sda_o",     32'(bus.sda_o), 0);
        check("rst_scl_o",     32'(bus.scl_o), 0);
        reset_n = 1'b1;
        clks(4);

        // Single instruction byte
        i2c_start();
        send_byte(8'h7C, "t1_addr_ack");
        check("t1_busy_addressed", 32'(bus.busy), 1);
        send_byte(8'h80, "t1_ctrl_ack");
        send_byte(8'h38, "t1_data_ack");
        i2c_stop();
        check("t1_busy_after_stop", 32'(bus.busy), 0);
        check("t1_out_count", out_cnt, 1);
        check("t1_last_out", 32'(last_out), 'h038);

        // Co=0 data streaming
        cnt0 = out_cnt;
        i2c_start();
        send_byte(8'h7C, "t2_addr_ack");
        send_byte(8'h40, "t2_ctrl_ack");
        send_byte(8'h49, "t2_data0_ack");
        send_byte(8'h20, "t2_data1_ack");
        send_byte(8'h4C, "t2_data2_ack");
        i2c_stop();
        check("t2_out_count", out_cnt - cnt0, 3);
        check("t2_last_out", 32'(last_out), 'h14C);

        // Wrong address and read request are ignored
        cnt0 = out_cnt;
        low0 = sda_low_cnt;
        i2c_start();
        send_byte(8'h78, "t3_wrong_addr_nack");
        check("t3_busy_wrong_addr", 32'(bus.busy), 0);
        send_byte(8'h55, "t3_ignored_nack");
        i2c_stop();
        i2c_start();
        send_byte(8'h7D, "t3_read_nack");
        check("t3_busy_read", 32'(bus.busy), 0);
        send_byte(8'h01, "t3_ignored2_nack");
        i2c_stop();
        check("t3_sda_never_low", sda_low_cnt - low0, 0);
        check("t3_no_output", out_cnt - cnt0, 0);

        // Consumer stalled: holding register full
        bus.cmd_ready = 1'b0;
        m_ready_low   = 1'b1;
        m_full        = 1'b0;
        i2c_start();
        send_byte(8'h7C, "t4_addr_ack");
        send_byte(8'h40, "t4_ctrl_ack");
        send_byte(8'h41, "t4_byte41_ack");
`ifdef LCD_I2C_TARGET_STRETCH_EN
        fork
            send_byte(8'h42, "t4_byte42_ack");
            begin
                for (int w = 0; w < 3000 && bus.scl_t !== 1'b0; w++) clks(1);
                check("t4_scl_stretched", 32'(bus.scl_t), 0);
                clks(20);
                check("t4_scl_held_low", 32'(bus.scl_i), 0);
                bus.cmd_ready = 1'b1;
                clks(1);
                bus.cmd_ready = 1'b0;
            end
        join
        i2c_stop();
        check("t4_overflow", 32'(bus.overflow), 0);
        check("t4_valid_after_stop", 32'(bus.cmd_valid), 1);
        check("t4_cmd_data", 32'(bus.cmd_data), 'h42);
`else
        send_byte(8'h42, "t4_byte42_nack");
        i2c_stop();
        check("t4_overflow", 32'(bus.overflow), 1);
        check("t4_valid_after_stop", 32'(bus.cmd_valid), 1);
        check("t4_cmd_data", 32'(bus.cmd_data), 'h41);
`endif
        check("t4_cmd_rs", 32'(bus.cmd_rs), 1);
        bus.cmd_ready = 1'b1;
        clks(2);
        m_ready_low = 1'b0;
        m_full      = 1'b0;
        check("t4_drained", 32'(bus.cmd_valid), 0);

        // Repeated START inside a data byte
        cnt0 = out_cnt;
        i2c_start();
        send_byte(8'h7C, "t5_addr_ack");
        send_byte(8'h40, "t5_ctrl_ack");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        i2c_start();
        send_byte(8'h7C, "t5_addr2_ack");
        send_byte(8'h80, "t5_ctrl2_ack");
        send_byte(8'h01, "t5_data_ack");
        i2c_stop();
        check("t5_out_count", out_cnt - cnt0, 1);
        check("t5_last_out", 32'(last_out), 'h001);

        // Reset during the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : (8'h7C >> i) & 1'b1 ? 1'b1 : 1'b0);
        tb_sda = 1'b1;
        clks(4);
        scl_up();
        clks(2);
        check("t6_ack_driven", 32'(bus.sda_t), 0);
        reset_n = 1'b0;
        clks(1);
        check("t6_sda_released", 32'(bus.sda_t), 1);
        check("t6_busy_cleared", 32'(bus.busy), 0);
        check("t6_overflow_cleared", 32'(bus.overflow), 0);
        reset_n = 1'b1;
        clks(HALF);
        tb_scl = 1'b0;
        clks(HALF);
        i2c_stop();
        cnt0 = out_cnt;
        i2c_start();
        send_byte(8'h7C, "t6_addr_ack");
        send_byte(8'h80, "t6_ctrl_ack");
        send_byte(8'h0C, "t6_data_ack");
        i2c_stop();
        check("t6_out_count", out_cnt - cnt0, 1);
        check("t6_last_out", 32'(last_out), 'h00C);

        clks(4);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_i2c_target.md
Name: lcd_i2c_target

Overview:
- I2C target (responder) that models the LCD controller at the far end of the axi_iic bus.
- Oversamples SCL/SDA on the system clock, detects START/STOP, and matches the 7-bit device address.
- ACKs and parses AiP31068-style control bytes (Co, RS), then presents each decoded command/data byte on a valid/ready output.
- Used as bus-functional LCD in simulation and as on-chip loopback target for the I2C driver.

Parameters:
- DEV_ADDR, 7'h3E, 7-bit target address; write header byte 0x7C.
- SYNC_STAGES, 2, synchronizer flops on scl_i and sda_i (minimum 2).

Ports:
- clk  in  1  system clock (sys_clk domain).
- reset_n  in  1  synchronous, active-low reset.
- scl_i  in  1  SCL from IOBUF.
- sda_i  in  1  SDA from IOBUF.
- sda_o  out  1  SDA drive value; constant 0.
- sda_t  out  1  SDA tristate: 1 = release, 0 = drive low.
- scl_o  out  1  SCL drive value; constant 0.
- scl_t  out  1  SCL tristate: 1 = release.
- cmd_valid  out  1  decoded byte available.
- cmd_rs  out  1  0 = instruction, 1 = DDRAM data.
- cmd_data  out  8  decoded byte.
- cmd_ready  in  1  consumer accepts; transfer occurs when cmd_valid && cmd_ready.
- busy  out  1  target is addressed; high from address ACK until STOP or START.
- overflow  out  1  sticky; set when a byte is lost; cleared only by reset.

Behaviour:

Reset values:
- sda_t=1, scl_t=1, cmd_valid=0, cmd_rs=0, cmd_data=0, busy=0, overflow=0.
- FSM = IDLE.
- Synchronizers preset to 1.
- Reset mid-transfer releases SDA in the same cycle reset is sampled.

Edge detection:
- Run on the synchronized signals, delayed one extra flop.
- SCL rise/fall = change of synced SCL.
- START = SDA falls while SCL high. STOP = SDA rises while SCL high.
- START/STOP is recognised in any state and takes priority over bit processing.
- START (including repeated START) moves FSM to ADDR, bit_cnt=0, busy=0.
- STOP moves FSM to IDLE, busy=0, and releases SDA.

Bit and ACK timing:
- Data bits are sampled MSB first on SCL rise; bit_cnt is 3 bits.
- On the SCL fall after bit 7, an ACK drives sda_t=0.
- ACK is held through the 9th SCL pulse and released on the following SCL fall.
- A NACK leaves sda_t=1.

FSM states:
- IDLE: wait for START.
- ADDR: after 8 bits, if byte[7:1]==DEV_ADDR and byte[0]==0, go to ADDR_ACK with busy=1. Otherwise (wrong address or read request) go to IGNORE; no ACK, no output.
- ADDR_ACK: drive ACK, then go to CTRL.
- CTRL: after 8 bits, latch co=byte[7] and rs=byte[6]; bits [5:0] ignored. Go to CTRL_ACK, which always ACKs, then DATA.
- DATA: after 8 bits, decide ACK before entering DATA_ACK.
  - If cmd_valid==0, or cmd_ready is high in that same cycle: load cmd_data=byte and cmd_rs=rs, assert cmd_valid, ACK.
  - Otherwise: keep the holding register unchanged, set overflow, NACK, and go to IGNORE after the ACK slot.
- DATA_ACK: after release, go to CTRL if co==1, else DATA. With co==0, every further byte is data carrying the last rs.
- IGNORE: SDA released; wait for START/STOP.

Output handshake:
- cmd_valid stays high until handshake.
- A load and a handshake in the same cycle keep cmd_valid=1 with the new byte.
- Data output latency: cmd_valid rises 2 clk after the synchronized SCL fall following bit 7.
- A STOP does not drop a pending cmd_valid.

Optional Feature:
- Macro LCD_I2C_TARGET_STRETCH_EN.
- Defined: when a DATA byte completes with the holding register full (cmd_valid && !cmd_ready), hold scl_t=0 from the SCL fall after bit 7 until the handshake. Then load the byte, ACK, and release SCL one clk later. overflow never sets.
- Undefined: scl_t is constant 1 and the NACK/overflow path above applies.

Test Plan:
- START, 0x7C, 0x80, 0x38, STOP with cmd_ready=1 → ACK on all 3 bytes; one cmd_valid pulse with rs=0, data=0x38; busy returns to 0 after STOP.
- START, 0x7C, 0x40, 0x49 ("I"), 0x20, 0x4C, STOP → three outputs with rs=1: 0x49, 0x20, 0x4C (Co=0 streaming).
- START, 0x78 (wrong address) and separately START, 0x7D (read) → SDA never driven low; no cmd_valid; busy stays 0.
- cmd_ready=0, send 0x7C, 0x40, 0x41, 0x42 → 0x41 held; 0x42 NACKed; overflow=1; cmd_data remains 0x41. With STRETCH_EN: SCL held low until cmd_ready pulses, then 0x42 is ACKed.
- Repeated START after bit 3 of a data byte, then 0x7C, 0x80, 0x01 → partial byte discarded; single output rs=0, data=0x01.
- reset_n low for 1 clk during the ACK of 0x7C → sda_t=1 next cycle; FSM in IDLE; the next full transaction decodes correctly.
